// File: rtl/sseg_scan_capture.sv
// Seven-segment display bus reader.
// Samples the multiplexed anode/segment lines, waits for each scan slot to hold
// steady for STABLE_CYCLES samples, then decodes the segment pattern back to a
// hex nibble and assembles the full displayed value one digit at a time.
module sseg_scan_capture #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIGITS-1:0]   anodes,
  input  logic [6:0]            seven_seg,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] hex_value,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic                  pattern_error,
  output logic                  frame_done
);

  localparam int SW = N_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_ARM = CW'(STABLE_CYCLES - 2);

  logic [SW-1:0]       sample_reg;
  logic [CW-1:0]       cnt_reg;
  logic [CW-1:0]       cnt_next;
  logic                accept_reg;
  logic [N_DIGITS-1:0] seen_reg;
  logic [N_DIGITS-1:0] seen_next;
  logic                perr_reg;
  logic                fdone_reg;

  logic [SW-1:0]       in_vec;
  logic                match;
  logic [N_DIGITS-1:0] slot_act;
  logic [6:0]          slot_seg;
  logic                any_on;
  logic                one_hot;
  logic                multi_on;
  logic                seg_ok;
  logic                seg_blank;
  logic [3:0]          seg_code;
  logic                frame_full;

  assign in_vec   = {anodes, seven_seg};
  assign match    = (in_vec == sample_reg);

  // The slot being processed is the one held in the sample register: it is
  // exactly the pattern that armed accept_reg on the previous edge.
  assign slot_act = ~sample_reg[SW-1:7];
  assign slot_seg = sample_reg[6:0];
  assign any_on   = |slot_act;
  assign one_hot  = any_on && ((slot_act & (slot_act - N_DIGITS'(1))) == '0);
  assign multi_on = any_on && !one_hot;

  assign seen_next  = seen_reg | slot_act;
  assign frame_full = (seen_next == '1);

  // Stability counter: counts repeated samples, saturating so a held pattern arms once
  always_comb begin
    cnt_next = '0;
    if (match) begin
      cnt_next = (cnt_reg == C_MAX) ? C_MAX : cnt_reg + CW'(1);
    end
  end

  // Segment pattern (g..a) back to hex code; blank and illegal are flagged separately
  always_comb begin
    seg_ok    = 1'b1;
    seg_blank = 1'b0;
    seg_code  = 4'h0;
    case (slot_seg)
      7'b1000000: seg_code = 4'h0;
      7'b1111001: seg_code = 4'h1;
      7'b0100100: seg_code = 4'h2;
      7'b0110000: seg_code = 4'h3;
      7'b0011001: seg_code = 4'h4;
      7'b0010010: seg_code = 4'h5;
      7'b0000010: seg_code = 4'h6;
      7'b1111000: seg_code = 4'h7;
      7'b0000000: seg_code = 4'h8;
      7'b0010000: seg_code = 4'h9;
      7'b0001000: seg_code = 4'hA;
      7'b0000011: seg_code = 4'hB;
      7'b1000110: seg_code = 4'hC;
      7'b0100001: seg_code = 4'hD;
      7'b0000110: seg_code = 4'hE;
      7'b0001110: seg_code = 4'hF;
      7'b1111111: begin
        seg_ok    = 1'b0;
        seg_blank = 1'b1;
      end
      default: seg_ok = 1'b0;
    endcase
  end

  // Sampling, accept arming, frame tracking and the one-cycle status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_reg <= '0;
      cnt_reg    <= '0;
      accept_reg <= 1'b0;
      seen_reg   <= '0;
      perr_reg   <= 1'b0;
      fdone_reg  <= 1'b0;
    end else begin
      sample_reg <= in_vec;
      perr_reg   <= 1'b0;
      fdone_reg  <= 1'b0;
      if (clear) begin
        cnt_reg    <= '0;
        accept_reg <= 1'b0;
        seen_reg   <= '0;
      end else begin
        cnt_reg    <= cnt_next;
        accept_reg <= match && (cnt_reg == C_ARM);
        if (accept_reg && one_hot) begin
          if (frame_full) begin
            seen_reg  <= '0;
            fdone_reg <= 1'b1;
          end else begin
            seen_reg <= seen_next;
          end
          if (!seg_ok && !seg_blank) begin
            perr_reg <= 1'b1;
          end
        end
        if (accept_reg && multi_on) begin
          perr_reg <= 1'b1;
        end
      end
    end
  end

  // Per-digit captured nibble and its valid flag
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [3:0] nib_reg;
      logic       vld_reg;

      // Update only when this digit is the single enabled anode of an accepted slot
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          nib_reg <= 4'h0;
          vld_reg <= 1'b0;
        end else if (accept_reg && one_hot && slot_act[gi]) begin
          if (seg_ok) begin
            nib_reg <= seg_code;
            vld_reg <= 1'b1;
          end else begin
            vld_reg <= 1'b0;
          end
        end
      end

      assign hex_value[4*gi +: 4] = nib_reg;
      assign digit_valid[gi]      = vld_reg;
    end
  endgenerate

  assign pattern_error = perr_reg;
  assign frame_done    = fdone_reg;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Bench for sseg_scan_capture: directed scenarios plus randomized scan traffic,
// all compared every cycle against a slot-level behavioural model.
module tb_sseg_scan_capture;

  localparam int N  = 8;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  anodes;
  logic [6:0]    seven_seg;
  logic          clear;
  logic [4*N-1:0] hex_value;
  logic [N-1:0]  digit_valid;
  logic          pattern_error;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;
  int perr_cnt = 0;
  int fd_cnt   = 0;

  logic [6:0] seg_tab [16];

  // Model state: captured value plus "how long has this input been held"
  logic [4*N-1:0] m_hex;
  logic [N-1:0]   m_valid;
  logic [N-1:0]   m_seen;
  logic           m_perr;
  logic           m_fd;
  logic [N+6:0]   m_last;
  int             m_run;
  bit             m_pend;
  logic [N+6:0]   m_pat;

  sseg_scan_capture #(.N_DIGITS(N), .STABLE_CYCLES(ST)) dut (
    .clk(clk), .reset(reset), .anodes(anodes), .seven_seg(seven_seg),
    .clear(clear), .hex_value(hex_value), .digit_valid(digit_valid),
    .pattern_error(pattern_error), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply an accepted slot the way the display semantics describe it
  task automatic model_accept(input logic [N+6:0] pat);
    logic [N-1:0] act;
    logic [6:0]   sg;
    int           ones;
    int           idx;
    int           code;
    act  = ~pat[N+6:7];
    sg   = pat[6:0];
    ones = 0;
    idx  = 0;
    code = -1;
    for (int i = 0; i < N; i++) if (act[i]) begin ones++; idx = i; end
    if (ones > 1) begin
      m_perr = 1'b1;
    end else if (ones == 1) begin
      m_seen[idx] = 1'b1;
      for (int k = 0; k < 16; k++) if (seg_tab[k] == sg) code = k;
      if (code >= 0) begin
        m_hex[4*idx +: 4] = 4'(code);
        m_valid[idx] = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        if (sg != 7'h7F) m_perr = 1'b1;
      end
      if (m_seen == '1) begin
        m_fd   = 1'b1;
        m_seen = '0;
      end
    end
  endtask

  // One clock: drive inputs, advance model, compare every output
  task automatic step(input logic [N-1:0] an, input logic [6:0] sg, input bit clr, input bit rst);
    logic [N+6:0] inv;
    @(negedge clk);
    anodes    = an;
    seven_seg = sg;
    clear     = clr;
    reset     = rst;
    inv       = {an, sg};
    @(posedge clk);
    m_perr = 1'b0;
    m_fd   = 1'b0;
    if (rst) begin
      m_hex = '0; m_valid = '0; m_seen = '0;
      m_last = '0; m_run = 1; m_pend = 1'b0;
    end else if (clr) begin
      m_hex = '0; m_valid = '0; m_seen = '0;
      m_last = inv; m_run = 1; m_pend = 1'b0;
    end else begin
      if (m_pend) model_accept(m_pat);
      if (inv == m_last) m_run = (m_run < ST + 1) ? m_run + 1 : m_run;
      else m_run = 1;
      m_last = inv;
      m_pend = (m_run == ST);
      m_pat  = inv;
    end
    #1;
    check("hex_value", 64'(hex_value), 64'(m_hex));
    check("digit_valid", 64'(digit_valid), 64'(m_valid));
    check("pattern_error", 64'(pattern_error), 64'(m_perr));
    check("frame_done", 64'(frame_done), 64'(m_fd));
    if (pattern_error) perr_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic hold(input logic [N-1:0] an, input logic [6:0] sg, input int n);
    for (int i = 0; i < n; i++) step(an, sg, 1'b0, 1'b0);
  endtask

  task automatic scan_frame(input int per);
    for (int d = 0; d < N; d++) hold(~(N'(1) << d), seg_tab[d + 1], per);
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    anodes = '1; seven_seg = '1; clear = 1'b0; reset = 1'b1;

    // Reset state
    step('1, 7'h7F, 1'b0, 1'b1);
    step('1, 7'h7F, 1'b0, 1'b1);
    check("reset_hex", 64'(hex_value), 64'h0);
    check("reset_valid", 64'(digit_valid), 64'h0);

    // First slot: digit 0 showing '2', visible at the fifth edge
    hold(8'hFE, 7'b0100100, 4);
    check("first_not_yet", 64'(digit_valid), 64'h0);
    hold(8'hFE, 7'b0100100, 1);
    check("first_nibble", 64'(hex_value[3:0]), 64'h2);
    check("first_valid", 64'(digit_valid), 64'h01);
    check("first_no_frame", 64'(frame_done), 64'h0);

    // Full frame 1..8
    step('1, 7'h7F, 1'b1, 1'b0);
    fd_cnt = 0;
    scan_frame(6);
    check("frame_hex", 64'(hex_value), 64'h87654321);
    check("frame_valid", 64'(digit_valid), 64'hFF);
    check("frame_pulses", 64'(fd_cnt), 64'd1);

    // Too-short slot is never accepted
    perr_cnt = 0;
    hold(8'hF7, seg_tab[9], 3);
    hold('1, 7'h7F, 4);
    check("short_hex", 64'(hex_value), 64'h87654321);
    check("short_valid", 64'(digit_valid), 64'hFF);
    check("short_perr", 64'(perr_cnt), 64'd0);

    // Two anodes on, illegal segments, blank
    hold(8'hFC, seg_tab[0], 4);
    hold('1, 7'h7F, 2);
    check("multi_perr", 64'(perr_cnt), 64'd1);
    check("multi_hex", 64'(hex_value), 64'h87654321);
    check("multi_valid", 64'(digit_valid), 64'hFF);
    hold(8'hDF, 7'b1010101, 5);
    hold('1, 7'h7F, 1);
    check("illegal_perr", 64'(perr_cnt), 64'd2);
    check("illegal_valid", 64'(digit_valid), 64'hDF);
    hold(8'hDF, seg_tab[3], 5);
    hold(8'hDF, 7'h7F, 5);
    check("blank_perr", 64'(perr_cnt), 64'd2);
    check("blank_valid", 64'(digit_valid), 64'hDF);
    check("blank_hex", 64'(hex_value), 64'h87354321);

    // Clear on the edge that would complete the second frame
    step('1, 7'h7F, 1'b1, 1'b0);
    scan_frame(6);
    fd_cnt = 0;
    for (int d = 0; d < N - 1; d++) hold(~(N'(1) << d), seg_tab[d + 1], 6);
    hold(8'h7F, seg_tab[8], 4);
    step(8'h7F, seg_tab[8], 1'b1, 1'b0);
    check("clear_hex", 64'(hex_value), 64'h0);
    check("clear_valid", 64'(digit_valid), 64'h0);
    check("clear_frames", 64'(fd_cnt), 64'd0);

    // Long hold accepted once, then reset restarts the stability window
    hold(8'hFE, seg_tab[15], 50);
    check("long_nibble", 64'(hex_value), 64'hF);
    check("long_valid", 64'(digit_valid), 64'h01);
    step(8'hFE, seg_tab[15], 1'b0, 1'b1);
    check("rst_hex", 64'(hex_value), 64'h0);
    check("rst_valid", 64'(digit_valid), 64'h0);
    hold(8'hFE, seg_tab[15], 4);
    check("rst_wait", 64'(digit_valid), 64'h0);
    hold(8'hFE, seg_tab[15], 1);
    check("rst_reaccept", 64'(digit_valid), 64'h01);

    // Randomized scan traffic
    for (int s = 0; s < 400; s++) begin
      int d, kind, len;
      logic [N-1:0] an;
      logic [6:0]   sg;
      d    = $urandom_range(0, N - 1);
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 7);
      an   = ~(N'(1) << d);
      sg   = seg_tab[$urandom_range(0, 15)];
      if (kind == 0) an = N'($urandom);
      else if (kind == 1) sg = 7'($urandom);
      else if (kind == 2) sg = 7'h7F;
      else if (kind == 3) an = '1;
      for (int c = 0; c < len; c++) step(an, sg, ($urandom_range(0, 59) == 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
